// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the EX/MEM pipeline-register layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Writeback select encoding
  localparam logic [1:0] ResultSrcAlu = 2'b00;
  localparam logic [1:0] ResultSrcMem = 2'b01;
  localparam logic [1:0] ResultSrcPc4 = 2'b10;

  // RV32I load/store funct3 encoding
  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc_plus4;
  } ex_mem_t;

  localparam ex_mem_t ExMemBubble = '0;

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM: byte-enabled synchronous write, combinational read.
module data_memory
  import riscv_pkg::*;
#(
  parameter int unsigned Words = 64,
  parameter int unsigned AddrW = $clog2(Words)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [AddrW-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_q [Words];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage: EX/MEM register, data memory and load extension.
// Define DMEM_BYTE_ACCESS_EN for LB/LH/LBU/LHU/SB/SH; otherwise all accesses are words.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallM,
  input  logic        FlushM,
  input  logic        RegWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic        MemWriteE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  RdE,
  input  logic [31:0] PCPlus4E,
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [31:0] ReadDataM
);

  localparam int unsigned AddrW = $clog2(DMEM_WORDS);

  ex_mem_t         ex_mem_d, ex_mem_q;
  logic            we;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, rdata;

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!StallM) begin
      if (FlushM) begin
        ex_mem_d = ExMemBubble;
      end else begin
        ex_mem_d = '{reg_write:  RegWriteE,
                     result_src: ResultSrcE,
                     mem_write:  MemWriteE,
                     funct3:     Funct3E,
                     alu_result: ALUResultE,
                     write_data: WriteDataE,
                     rd:         RdE,
                     pc_plus4:   PCPlus4E};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_mem_q <= ExMemBubble;
    else       ex_mem_q <= ex_mem_d;
  end

  // A store held in M commits only on the edge that releases it; reset drops it.
  assign we = ex_mem_q.mem_write & ~StallM & ~reset;

`ifdef DMEM_BYTE_ACCESS_EN
  logic [1:0]      byte_off;
  logic [XLEN-1:0] rd_shift;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    byte_off  = ex_mem_q.alu_result[1:0];
    be        = 4'b0000;
    wdata     = ex_mem_q.write_data;
    case (ex_mem_q.funct3)
      F3Byte: begin
        be    = 4'b0001 << byte_off;
        wdata = {4{ex_mem_q.write_data[7:0]}};
      end
      F3Half: begin
        be    = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ex_mem_q.write_data[15:0]}};
      end
      F3Word:  be = 4'b1111;
      default: be = 4'b0000;
    endcase

    rd_shift  = rdata >> {byte_off, 3'b000};
    ld_byte   = rd_shift[7:0];
    ld_half   = byte_off[1] ? rdata[31:16] : rdata[15:0];
    ReadDataM = rdata;
    case (ex_mem_q.funct3)
      F3Byte:  ReadDataM = {{24{ld_byte[7]}}, ld_byte};
      F3Half:  ReadDataM = {{16{ld_half[15]}}, ld_half};
      F3ByteU: ReadDataM = {24'b0, ld_byte};
      F3HalfU: ReadDataM = {16'b0, ld_half};
      default: ReadDataM = rdata;
    endcase
  end
`else
  logic unused_funct3;

  assign be            = 4'b1111;
  assign wdata         = ex_mem_q.write_data;
  assign ReadDataM     = rdata;
  assign unused_funct3 = ^ex_mem_q.funct3;
`endif

  data_memory #(
    .Words (DMEM_WORDS)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .addr  (ex_mem_q.alu_result[AddrW+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign RegWriteM  = ex_mem_q.reg_write;
  assign ResultSrcM = ex_mem_q.result_src;
  assign RdM        = ex_mem_q.rd;
  assign ALUResultM = ex_mem_q.alu_result;
  assign PCPlus4M   = ex_mem_q.pc_plus4;

endmodule

// File: tb/tb_memory_stage.sv
// Directed plus random bench for memory_stage against a byte-array reference model.
module tb_memory_stage;

  localparam int unsigned Words = 64;

  logic        clk = 1'b0;
  logic        reset, StallM, FlushM;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, PCPlus4M, ReadDataM;

  always #5 clk = ~clk;

  memory_stage #(
    .DMEM_WORDS (Words)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .StallM     (StallM),
    .FlushM     (FlushM),
    .RegWriteE  (RegWriteE),
    .ResultSrcE (ResultSrcE),
    .MemWriteE  (MemWriteE),
    .Funct3E    (Funct3E),
    .ALUResultE (ALUResultE),
    .WriteDataE (WriteDataE),
    .RdE        (RdE),
    .PCPlus4E   (PCPlus4E),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .PCPlus4M   (PCPlus4M),
    .ReadDataM  (ReadDataM)
  );

  // Reference model: memory as a flat byte array, M-stage contents as plain variables
  logic [7:0]  mem_m [4*Words];
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_wd, m_pc;
  logic [4:0]  m_rd;
  bit          mem_ready = 1'b0;
  int unsigned vectors = 0, checks = 0, miscompares = 0;
  logic [31:0] old_val;

  function automatic int unsigned base_of(logic [31:0] a);
    return ((a >> 2) % Words) * 4;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, logic [2:0] f3);
    int unsigned b;
    logic [31:0] w;
`ifdef DMEM_BYTE_ACCESS_EN
    logic [7:0]  by;
    logic [15:0] h;
`endif
    b = base_of(a);
    w = {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
`ifdef DMEM_BYTE_ACCESS_EN
    by = mem_m[b + int'(a[1:0])];
    h  = {mem_m[b + 2*int'(a[1]) + 1], mem_m[b + 2*int'(a[1])]};
    case (f3)
      3'd0:    return {{24{by[7]}}, by};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, by};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
`else
    return w;
`endif
  endfunction

  task automatic model_store(logic [31:0] a, logic [2:0] f3, logic [31:0] d);
    int unsigned b;
    b = base_of(a);
`ifdef DMEM_BYTE_ACCESS_EN
    case (f3)
      3'd0: mem_m[b + int'(a[1:0])] = d[7:0];
      3'd1: begin
        mem_m[b + 2*int'(a[1])]     = d[7:0];
        mem_m[b + 2*int'(a[1]) + 1] = d[15:8];
      end
      3'd2: for (int i = 0; i < 4; i++) mem_m[b+i] = d[8*i +: 8];
      default: ;
    endcase
`else
    for (int i = 0; i < 4; i++) mem_m[b+i] = d[8*i +: 8];
`endif
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("RegWriteM",  {31'd0, RegWriteM}, {31'd0, m_rw});
    check("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, m_rs});
    check("RdM",        {27'd0, RdM}, {27'd0, m_rd});
    check("ALUResultM", ALUResultM, m_alu);
    check("PCPlus4M",   PCPlus4M, m_pc);
    if (mem_ready) check("ReadDataM", ReadDataM, model_load(m_alu, m_f3));
  endtask

  task automatic drive(logic rw, logic [1:0] rs, logic mw, logic [2:0] f3,
                       logic [31:0] alu, logic [31:0] wd, logic [4:0] rd, logic [31:0] pc);
    RegWriteE = rw; ResultSrcE = rs; MemWriteE = mw; Funct3E = f3;
    ALUResultE = alu; WriteDataE = wd; RdE = rd; PCPlus4E = pc;
  endtask

  // One clock edge: update the model from the rules, then compare after the edge
  task automatic step();
    bit wr;
    wr = (m_mw === 1'b1) && !StallM && !reset;
    @(posedge clk);
    if (wr) model_store(m_alu, m_f3, m_wd);
    if (reset || (!StallM && FlushM)) begin
      m_rw = 0; m_rs = 0; m_mw = 0; m_f3 = 0; m_alu = 0; m_wd = 0; m_rd = 0; m_pc = 0;
    end else if (!StallM) begin
      m_rw = RegWriteE; m_rs = ResultSrcE; m_mw = MemWriteE; m_f3 = Funct3E;
      m_alu = ALUResultE; m_wd = WriteDataE; m_rd = RdE; m_pc = PCPlus4E;
    end
    vectors++;
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1; StallM = 0; FlushM = 0;
    drive(0, 2'b00, 0, 3'd0, 0, 0, 0, 0);
    m_mw = 0;
    step();
    step();
    reset = 0;

    // a) idle after reset
    step();
    check("a_RegWriteM", {31'd0, RegWriteM}, 32'd0);
    check("a_RdM", {27'd0, RdM}, 32'd0);
    check("a_ALUResultM", ALUResultM, 32'd0);
    check("a_PCPlus4M", PCPlus4M, 32'd0);

    // Give every word a known value
    for (int i = 0; i < int'(Words); i++) begin
      drive(0, 2'b00, 1, 3'd2, 32'(i*4), $urandom, 0, 0);
      step();
    end
    drive(0, 2'b00, 0, 3'd2, 0, 0, 0, 0);
    step();
    mem_ready = 1'b1;

    // b) pass-through
    drive(1, 2'b00, 0, 3'd2, 32'h9, 0, 5'd3, 32'h28);
    step();
    check("b_RegWriteM", {31'd0, RegWriteM}, 32'd1);
    check("b_RdM", {27'd0, RdM}, 32'd3);
    check("b_ALUResultM", ALUResultM, 32'h9);
    check("b_PCPlus4M", PCPlus4M, 32'h28);

    // c) store then load, plus aliased address
    drive(0, 2'b00, 1, 3'd2, 32'h10, 32'h5555, 0, 0);
    step();
    drive(1, 2'b01, 0, 3'd2, 32'h10, 0, 5'd4, 0);
    step();
    check("c_lw", ReadDataM, 32'h0000_5555);
    drive(1, 2'b01, 0, 3'd2, 32'h10 + 4*Words, 0, 5'd4, 0);
    step();
    check("c_lw_wrap", ReadDataM, 32'h0000_5555);

    // d) stalled store: held outputs, no early write, flush loses to stall
    old_val = model_load(32'h30, 3'd2);
    drive(0, 2'b00, 1, 3'd2, 32'h30, 32'hCC, 0, 32'h44);
    step();
    StallM = 1;
    drive(1, 2'b01, 0, 3'd2, 32'h30, 0, 5'd7, 32'h48);
    step();
    check("d_hold_alu", ALUResultM, 32'h30);
    check("d_no_early_write", ReadDataM, old_val);
    FlushM = 1;
    step();
    check("d_stall_beats_flush", PCPlus4M, 32'h44);
    check("d_still_old", ReadDataM, old_val);
    StallM = 0; FlushM = 0;
    step();
    check("d_lw_after_stall", ReadDataM, 32'hCC);
    check("d_rd", {27'd0, RdM}, 32'd7);

    // e) flushed store must not write
    old_val = model_load(32'h20, 3'd2);
    FlushM = 1;
    drive(1, 2'b00, 1, 3'd2, 32'h20, 32'hAA, 5'd9, 0);
    step();
    check("e_RegWriteM", {31'd0, RegWriteM}, 32'd0);
    FlushM = 0;
    drive(1, 2'b01, 0, 3'd2, 32'h20, 0, 5'd9, 0);
    step();
    check("e_mem_unchanged", ReadDataM, old_val);

    // Store pending in M when reset asserts is dropped
    old_val = model_load(32'h40, 3'd2);
    drive(0, 2'b00, 1, 3'd2, 32'h40, 32'h1234, 0, 0);
    step();
    reset = 1;
    drive(0, 2'b00, 0, 3'd2, 0, 0, 0, 0);
    step();
    reset = 0;
    drive(1, 2'b01, 0, 3'd2, 32'h40, 0, 5'd1, 0);
    step();
    check("reset_drops_store", ReadDataM, old_val);

`ifdef DMEM_BYTE_ACCESS_EN
    // f) sub-word accesses
    drive(0, 2'b00, 1, 3'd2, 32'h0, 32'h80FF_7F01, 0, 0);
    step();
    drive(1, 2'b01, 0, 3'd0, 32'h3, 0, 5'd2, 0);
    step();
    check("f_lb", ReadDataM, 32'hFFFF_FF80);
    drive(1, 2'b01, 0, 3'd4, 32'h3, 0, 5'd2, 0);
    step();
    check("f_lbu", ReadDataM, 32'h0000_0080);
    drive(1, 2'b01, 0, 3'd1, 32'h2, 0, 5'd2, 0);
    step();
    check("f_lh", ReadDataM, 32'hFFFF_80FF);
    drive(0, 2'b00, 1, 3'd0, 32'h1, 32'h12, 0, 0);
    step();
    drive(1, 2'b01, 0, 3'd2, 32'h0, 0, 5'd2, 0);
    step();
    check("f_sb_lw", ReadDataM, 32'h80FF_1201);
`endif

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      reset  = ($urandom_range(0, 99) < 3);
      StallM = ($urandom_range(0, 99) < 25);
      FlushM = ($urandom_range(0, 99) < 10);
      drive($urandom_range(0, 1), 2'($urandom_range(0, 2)), $urandom_range(0, 1),
            3'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
      step();
    end
    reset = 0; StallM = 0; FlushM = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter DMEM_WORDS, default 64, data-memory depth in 32-bit words (power of two, 16..1024).
REQ-002 Ports, one per line: name  direction  width  meaning. Clock and reset are listed first.
  clk  in  1  sole clock; all state updates on rising edge
  reset  in  1  synchronous, active-high
  StallM  in  1  hold EX/MEM register contents
  FlushM  in  1  insert bubble into EX/MEM register
  RegWriteE  in  1  register-file write request
  ResultSrcE  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4
  MemWriteE  in  1  store request
  Funct3E  in  3  access size/sign (RV32I load/store encoding)
  ALUResultE  in  32  effective address or ALU result
  WriteDataE  in  32  store data (already forwarded)
  RdE  in  5  destination register
  PCPlus4E  in  32  link value
  RegWriteM  out  1  registered RegWriteE
  ResultSrcM  out  2  registered ResultSrcE
  RdM  out  5  registered RdE
  ALUResultM  out  32  registered ALUResultE; also the forwarding source to execute
  PCPlus4M  out  32  registered PCPlus4E
  ReadDataM  out  32  load data, sized and extended

Function
REQ-003 EX/MEM register SHALL capture every E input on each rising edge when StallM=0 and FlushM=0.
REQ-004 StallM=1 SHALL hold all register contents; StallM SHALL take priority over FlushM.
REQ-005 FlushM=1 with StallM=0 SHALL load a bubble: RegWriteM=0, MemWrite=0, ResultSrcM=00, RdM=0, and data fields 0.
REQ-006 Data memory SHALL be word-indexed by ALUResultM[log2(DMEM_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap around.
REQ-007 Read SHALL be combinational from the registered address, so ReadDataM is valid in the same cycle the instruction occupies M (zero-cycle load latency after the register).
REQ-008 Store SHALL commit on the rising edge ending the M cycle when the registered MemWrite=1 and StallM=0.
REQ-009 A load to the address stored in the previous cycle SHALL return the new data; a same-cycle read SHALL return the pre-write data.
REQ-010 A stalled store SHALL commit exactly once, on the edge where StallM falls.
REQ-011 Registered outputs SHALL change only on clk rising edges; ReadDataM SHALL be a function of the register and memory state only.

Reset
REQ-012 reset=1 SHALL force the EX/MEM register to the bubble value of REQ-005 on the next rising edge, overriding StallM and FlushM.
REQ-013 Data memory contents SHALL NOT be cleared by reset; any store pending in M when reset asserts SHALL be discarded.

Configuration
REQ-014 Macro DMEM_BYTE_ACCESS_EN compiled in: Funct3 000/001/010/100/101 SHALL select LB/LH/LW/LBU/LHU on load, and 000/001/010 SHALL select SB/SH/SW on store, with byte lanes taken from address[1:0]. Half-word accesses SHALL use address[1] and ignore address[0].
REQ-015 Macro DMEM_BYTE_ACCESS_EN absent: every access SHALL be a full word; Funct3E SHALL be ignored (and need not be registered); address[1:0] SHALL be ignored.

Structure
REQ-016 Package riscv_pkg SHALL hold XLEN=32, the ResultSrc encoding constants, and the Funct3 load/store constants.
REQ-017 Storage SHALL be a sub-module data_memory with these ports: clk, we, byte-enable[3:0], addr, wdata, rdata. The EX/MEM register and the load extend logic SHALL remain in memory_stage.

Verification
REQ-018 Each bench SHALL cover these scenarios:
  a) Reset, then idle -> RegWriteM=0, RdM=0, ALUResultM=0, PCPlus4M=0.
  b) E inputs RegWriteE=1, RdE=3, ALUResultE=0x9, PCPlus4E=0x28 for one edge -> M outputs are the same values after that edge.
  c) SW with ALUResultE=0x10 and WriteDataE=0x5555, then LW at 0x10 -> ReadDataM=0x00005555. Also LW at 0x10+4*DMEM_WORDS -> same value (wrap-around).
  d) StallM=1 for 2 cycles carrying a SW of 0xCC -> M outputs are held and exactly one write occurs. FlushM=1 together with StallM=1 -> hold wins.
  e) FlushM=1 on a SW of 0xAA at 0x20 -> memory unchanged and RegWriteM=0.
  f) With DMEM_BYTE_ACCESS_EN: SW 0x80FF7F01 at 0x0; then LB at 0x3 -> 0xFFFFFF80; LBU at 0x3 -> 0x80; LH at 0x2 -> 0xFFFF80FF; SB 0x12 at 0x1 then LW at 0x0 -> 0x80FF1201.
